// File: rtl/ecc_point_add.sv
// Sequential elliptic-curve point adder/doubler over GF(p).
// Collects Xp, Yp, Xq, Yq, p, a serially and returns R = P + Q six cycles
// after the last word, using one combinational modular inverse.

// Combinational modular inverse: the smallest k in [1, 2^WIDTH-1] with
// (val * k) mod m == 1. For prime m and val != 0 that k is below m.
module ecc_mod_inv #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] i_mod,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_inv
);
  logic [2*WIDTH-1:0] w_prod;

  // Descending search so the last hit (the smallest k) wins.
  always_comb begin
    o_inv  = '0;
    w_prod = '0;
    for (int k = (1 << WIDTH) - 1; k >= 1; k--) begin
      w_prod = {{WIDTH{1'b0}}, i_val} * (2*WIDTH)'(k);
      if ((i_mod != '0) && ((w_prod % {{WIDTH{1'b0}}, i_mod}) == (2*WIDTH)'(1)))
        o_inv = WIDTH'(k);
    end
  end
endmodule

module ecc_point_add #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_Rx,
  output logic [WIDTH-1:0] out_Ry
);
  // state   | meaning
  // IDLE    | wait for Xp
  // LOAD    | capture Yp, Xq, Yq, p, a
  // CALC_ND | form slope numerator / denominator
  // INV     | register inverse of the denominator
  // SLOPE   | s = num * inv
  // RX      | Rx = s^2 - Xp - Xq
  // RY      | Ry = s*(Xp - Rx) - Yp
  // OUT     | one-cycle result pulse
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CALC_ND, S_INV, S_SLOPE, S_RX, S_RY, S_OUT
  } state_t;

  localparam logic [WIDTH-1:0] C_TWO   = WIDTH'(2);
  localparam logic [WIDTH-1:0] C_THREE = WIDTH'(3);

  state_t r_state, w_state_nxt;
  logic [2:0]       r_cnt;
  logic [WIDTH-1:0] r_xp, r_yp, r_xq, r_yq, r_p, r_a;
  logic [WIDTH-1:0] r_num, r_den, r_inv, r_s, r_rx, r_ry;

  logic             w_dbl;
  logic [WIDTH-1:0] w_num, w_den, w_inv, w_s, w_rx, w_ry;

  function automatic logic [WIDTH-1:0] f_mod(input logic [2*WIDTH-1:0] v,
                                             input logic [WIDTH-1:0]   m);
    return WIDTH'(v % {{WIDTH{1'b0}}, m});
  endfunction

  function automatic logic [WIDTH-1:0] f_mul(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic [WIDTH-1:0] m);
    return f_mod({{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y}, m);
  endfunction

  function automatic logic [WIDTH-1:0] f_add(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic [WIDTH-1:0] m);
    return f_mod({{WIDTH{1'b0}}, x} + {{WIDTH{1'b0}}, y}, m);
  endfunction

  // x + m - y never goes negative because x, y < m.
  function automatic logic [WIDTH-1:0] f_sub(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic [WIDTH-1:0] m);
    return f_mod({{WIDTH{1'b0}}, x} + {{WIDTH{1'b0}}, m} - {{WIDTH{1'b0}}, y}, m);
  endfunction

  ecc_mod_inv #(.WIDTH(WIDTH)) u_inv (
    .i_mod (r_p),
    .i_val (r_den),
    .o_inv (w_inv)
  );

  // Field arithmetic for each stage, consumed only in the matching state.
  always_comb begin
    w_dbl = (r_xp == r_xq) && (r_yp == r_yq);
    w_num = '0;
    w_den = '0;
    if (w_dbl) begin
      w_num = f_add(f_mul(C_THREE, f_mul(r_xp, r_xp, r_p), r_p), r_a, r_p);
      w_den = f_mul(C_TWO, r_yp, r_p);
    end else begin
      w_num = f_sub(r_yq, r_yp, r_p);
      w_den = f_sub(r_xq, r_xp, r_p);
    end
    w_s  = f_mul(r_num, r_inv, r_p);
    w_rx = f_sub(f_sub(f_mul(r_s, r_s, r_p), r_xp, r_p), r_xq, r_p);
    w_ry = f_sub(f_mul(r_s, f_sub(r_xp, r_rx, r_p), r_p), r_yp, r_p);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and outputs; results are gated to zero outside OUT.
  always_comb begin
    w_state_nxt = r_state;
    out_valid   = 1'b0;
    out_Rx      = '0;
    out_Ry      = '0;
    case (r_state)
      S_IDLE:    if (in_valid) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (!in_valid)          w_state_nxt = S_IDLE;
        else if (r_cnt == 3'd4) w_state_nxt = S_CALC_ND;
      end
      S_CALC_ND: w_state_nxt = S_INV;
      S_INV:     w_state_nxt = S_SLOPE;
      S_SLOPE:   w_state_nxt = S_RX;
      S_RX:      w_state_nxt = S_RY;
      S_RY:      w_state_nxt = S_OUT;
      S_OUT: begin
        w_state_nxt = S_IDLE;
        out_valid   = 1'b1;
        out_Rx      = r_rx;
        out_Ry      = r_ry;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Word capture and per-stage datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_xp  <= '0;
      r_yp  <= '0;
      r_xq  <= '0;
      r_yq  <= '0;
      r_p   <= '0;
      r_a   <= '0;
      r_num <= '0;
      r_den <= '0;
      r_inv <= '0;
      r_s   <= '0;
      r_rx  <= '0;
      r_ry  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_xp  <= in_data;
            r_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            case (r_cnt)
              3'd0:    r_yp <= in_data;
              3'd1:    r_xq <= in_data;
              3'd2:    r_yq <= in_data;
              3'd3:    r_p  <= in_data;
              default: r_a  <= in_data;
            endcase
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_CALC_ND: begin
          r_num <= w_num;
          r_den <= w_den;
        end
        S_INV:   r_inv <= w_inv;
        S_SLOPE: r_s   <= w_s;
        S_RX:    r_rx  <= w_rx;
        S_RY:    r_ry  <= w_ry;
        default: ;
      endcase
    end
  end
endmodule
